// File: rtl/frame_render_sequencer.sv
// Per-frame sequencer: clears the display buffers, then issues one render start per
// object and counts completions until the frame's object count is reached.
module frame_render_sequencer #(
    parameter int MAX_NUM_OBJECTS_PER_FRAME = 1024,
    parameter int OBJ_COUNT_WIDTH           = $clog2(MAX_NUM_OBJECTS_PER_FRAME + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_frame_start,
    input  logic [OBJ_COUNT_WIDTH-1:0] i_num_objects,
    output logic                       o_ready,
    output logic                       o_clear,
    input  logic                       i_display_ready,
    output logic                       o_render_start,
    input  logic                       i_render_ready,
    input  logic                       i_render_finished,
    output logic [OBJ_COUNT_WIDTH-1:0] o_objects_rendered,
    output logic                       o_frame_done,
    output logic                       o_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_REQ,
        CLEAR_ACK,
        CLEAR_WAIT,
        RENDER_START,
        RENDER_WAIT,
        DONE
    } state_t;

    localparam logic [OBJ_COUNT_WIDTH-1:0] MAX_OBJ = OBJ_COUNT_WIDTH'(MAX_NUM_OBJECTS_PER_FRAME);
    localparam logic [OBJ_COUNT_WIDTH-1:0] ONE     = OBJ_COUNT_WIDTH'(1);

    state_t                     state;
    logic [OBJ_COUNT_WIDTH-1:0] num_obj;
    logic [OBJ_COUNT_WIDTH-1:0] capped_count;
    logic [OBJ_COUNT_WIDTH-1:0] next_count;

    assign capped_count = (i_num_objects > MAX_OBJ) ? MAX_OBJ : i_num_objects;
    assign next_count   = o_objects_rendered + ONE;

    // Pulse outputs default low each cycle and are set only on the transition that owns them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state              <= IDLE;
            num_obj            <= '0;
            o_objects_rendered <= '0;
            o_ready            <= 1'b1;
            o_clear            <= 1'b0;
            o_render_start     <= 1'b0;
            o_frame_done       <= 1'b0;
            o_overrun          <= 1'b0;
        end else begin
            o_clear        <= 1'b0;
            o_render_start <= 1'b0;
            o_frame_done   <= 1'b0;

            if (i_frame_start && (state != IDLE)) begin
                o_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_frame_start) begin
                        num_obj            <= capped_count;
                        o_objects_rendered <= '0;
                        o_overrun          <= 1'b0;
                        o_ready            <= 1'b0;
                        o_clear            <= 1'b1;
                        state              <= CLEAR_REQ;
                    end
                end
                CLEAR_REQ: begin
                    state <= CLEAR_ACK;
                end
                // A ready that never dropped is stale and must not count as clear completion.
                CLEAR_ACK: begin
                    if (!i_display_ready) begin
                        state <= CLEAR_WAIT;
                    end
                end
                CLEAR_WAIT: begin
                    if (i_display_ready) begin
                        if (num_obj == '0) begin
                            o_frame_done <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= RENDER_START;
                        end
                    end
                end
                RENDER_START: begin
                    if (i_render_ready) begin
                        o_render_start <= 1'b1;
                        state          <= RENDER_WAIT;
                    end
                end
                RENDER_WAIT: begin
                    if (i_render_finished) begin
                        o_objects_rendered <= next_count;
                        if (next_count == num_obj) begin
                            o_frame_done <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= RENDER_START;
                        end
                    end
                end
                DONE: begin
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Directed and randomized frames against a cycle-level display/render environment whose
// expectations come from frame-level rules (counts, latencies, pulse placement).
module tb_frame_render_sequencer;

    localparam int MAX_OBJ = 1024;
    localparam int CW      = $clog2(MAX_OBJ + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_frame_start;
    logic [CW-1:0] i_num_objects;
    logic          o_ready;
    logic          o_clear;
    logic          i_display_ready;
    logic          o_render_start;
    logic          i_render_ready;
    logic          i_render_finished;
    logic [CW-1:0] o_objects_rendered;
    logic          o_frame_done;
    logic          o_overrun;

    always #5 clk = ~clk;

    frame_render_sequencer #(
        .MAX_NUM_OBJECTS_PER_FRAME(MAX_OBJ)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_frame_start     (i_frame_start),
        .i_num_objects     (i_num_objects),
        .o_ready           (o_ready),
        .o_clear           (o_clear),
        .i_display_ready   (i_display_ready),
        .o_render_start    (o_render_start),
        .i_render_ready    (i_render_ready),
        .i_render_finished (i_render_finished),
        .o_objects_rendered(o_objects_rendered),
        .o_frame_done      (o_frame_done),
        .o_overrun         (o_overrun)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Expected outputs for the next sample, maintained from frame-level rules
    bit exp_ready, exp_ovr, clear_due, done_due, disp_back, in_reset;
    int exp_total, fin_count, start_due;
    int starts_seen, clears_seen, dones_seen;
    bit prev_start, idle_now, saw_done, saw_clear, saw_start;

    bit req_start, ovr_en, start_at_done;
    int req_n, rst_cycles;

    // Display and render environment models
    bit d_active;
    int d_stale, d_low, p_stale, p_low;
    int r_busy, r_bp, p_fd, p_bp;
    bit p_spur;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        i_frame_start     = 1'b0;
        i_render_finished = 1'b0;
        in_reset          = 1'b0;
        if (rst_cycles > 0) begin
            rst_cycles--;
            rstn      = 1'b0;
            in_reset  = 1'b1;
            exp_ready = 1'b1;
            exp_ovr   = 1'b0;
            fin_count = 0;
            start_due = 0;
            d_active  = 1'b0;
            r_busy    = 0;
            r_bp      = 0;
            i_display_ready = 1'b1;
            i_render_ready  = 1'b1;
            return;
        end
        rstn = 1'b1;

        if (req_start) begin
            req_start     = 1'b0;
            i_frame_start = 1'b1;
            i_num_objects = CW'(req_n);
            if (idle_now) begin
                exp_ready = 1'b0;
                exp_ovr   = 1'b0;
                fin_count = 0;
                clear_due = 1'b1;
                exp_total = (req_n > MAX_OBJ) ? MAX_OBJ : req_n;
                disp_back = 1'b0;
            end else begin
                exp_ovr = 1'b1;
            end
        end

        // Display: reacts one cycle after seeing clear, optionally keeps a stale ready, then drops
        if (saw_clear) begin
            d_active = 1'b1;
            d_stale  = p_stale;
            d_low    = p_low;
        end
        if (d_active) begin
            if (d_stale > 0) begin
                i_display_ready = 1'b1;
                d_stale--;
            end else if (d_low > 0) begin
                i_display_ready = 1'b0;
                d_low--;
                if (ovr_en && d_low == p_low - 3) begin
                    ovr_en        = 1'b0;
                    i_frame_start = 1'b1;
                    i_num_objects = CW'(9);
                    exp_ovr       = 1'b1;
                end
            end else begin
                i_display_ready = 1'b1;
                d_active        = 1'b0;
                disp_back       = 1'b1;
                if (exp_total == 0) done_due = 1'b1;
                else start_due = 2;
            end
        end

        // Render pipeline: busy for p_fd cycles per start, then back-pressure for p_bp cycles
        if (saw_start) begin
            r_busy = p_fd;
        end else if (r_busy > 0) begin
            r_busy--;
            if (r_busy == 0) begin
                i_render_finished = 1'b1;
                fin_count++;
                if (fin_count == exp_total) begin
                    done_due = 1'b1;
                    r_bp     = 0;
                end else begin
                    r_bp = p_bp;
                    if (p_bp == 0) start_due = 2;
                end
            end
        end else if (r_bp > 0) begin
            r_bp--;
            if (p_spur && r_bp == p_bp / 2 && fin_count < exp_total) i_render_finished = 1'b1;
            if (r_bp == 0 && fin_count < exp_total) start_due = 1;
        end
        i_render_ready = (r_busy == 0 && r_bp == 0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        checkOutput("ready", o_ready, exp_ready);
        checkOutput("objects_rendered", o_objects_rendered, fin_count);
        checkOutput("overrun", o_overrun, exp_ovr);
        checkOutput("clear", o_clear, clear_due);
        checkOutput("frame_done", o_frame_done, done_due);
        checkOutput("start_without_ready", o_render_start & ~i_render_ready, 0);
        checkOutput("start_width", o_render_start & prev_start, 0);
        checkOutput("start_before_display", o_render_start & ~disp_back, 0);
        if (start_due == 1) checkOutput("start_latency", o_render_start, 1);
        if (in_reset) checkOutput("start_in_reset", o_render_start, 0);

        saw_start = (o_render_start === 1'b1);
        saw_clear = (o_clear === 1'b1);
        saw_done  = (o_frame_done === 1'b1);
        if (saw_start) starts_seen++;
        if (saw_clear) clears_seen++;
        if (saw_done) dones_seen++;
        prev_start = saw_start;
        idle_now   = exp_ready;
        if (done_due) exp_ready = 1'b1;
        if (start_due > 0) start_due--;
        clear_due = 1'b0;
        done_due  = 1'b0;
        if (start_at_done && saw_done) begin
            start_at_done = 1'b0;
            req_start     = 1'b1;
            req_n         = 5;
        end
        applyStimulus();
    endtask

    task automatic runFrame(input string name, input int n, input int stale, input int low,
                            input int fd, input int bp, input bit spur, input bit ovr, input bit at_done);
        int want;
        int budget;
        int cyc;
        want          = (n > MAX_OBJ) ? MAX_OBJ : n;
        budget        = 50 + stale + low + want * (fd + bp + 4);
        p_stale       = stale;
        p_low         = low;
        p_fd          = fd;
        p_bp          = bp;
        p_spur        = spur;
        ovr_en        = ovr;
        start_at_done = at_done;
        starts_seen   = 0;
        clears_seen   = 0;
        dones_seen    = 0;
        req_start     = 1'b1;
        req_n         = n;
        cyc           = 0;
        stepCycle();
        while (dones_seen == 0 && cyc < budget) begin
            stepCycle();
            cyc++;
        end
        stepCycle();
        checkOutput({name, "_done_pulses"}, dones_seen, 1);
        checkOutput({name, "_clear_pulses"}, clears_seen, 1);
        checkOutput({name, "_start_pulses"}, starts_seen, want);
        checkOutput({name, "_final_count"}, o_objects_rendered, want);
        checkOutput({name, "_final_overrun"}, o_overrun, ovr | at_done);
        $display("[TB] frame %s: %0d objects requested, %0d starts", name, n, starts_seen);
    endtask

    initial begin
        int cyc;
        int n;
        int bp;
        rstn              = 1'b0;
        i_frame_start     = 1'b0;
        i_num_objects     = '0;
        i_display_ready   = 1'b1;
        i_render_ready    = 1'b1;
        i_render_finished = 1'b0;
        exp_ready = 1'b1; exp_ovr = 1'b0; clear_due = 1'b0; done_due = 1'b0;
        disp_back = 1'b0; in_reset = 1'b0; exp_total = 0; fin_count = 0; start_due = 0;
        starts_seen = 0; clears_seen = 0; dones_seen = 0;
        prev_start = 1'b0; idle_now = 1'b1; saw_done = 1'b0; saw_clear = 1'b0; saw_start = 1'b0;
        req_start = 1'b0; ovr_en = 1'b0; start_at_done = 1'b0; req_n = 0;
        d_active = 1'b0; d_stale = 0; d_low = 0; p_stale = 1; p_low = 1;
        r_busy = 0; r_bp = 0; p_fd = 1; p_bp = 0; p_spur = 1'b0;

        rst_cycles = 3;
        applyStimulus();
        repeat (6) stepCycle();

        runFrame("normal", 3, 1, 10, 20, 0, 1'b0, 1'b0, 1'b0);
        runFrame("zero_objects", 0, 1, 3, 5, 0, 1'b0, 1'b0, 1'b0);
        runFrame("backpressure", 3, 1, 4, 6, 15, 1'b1, 1'b0, 1'b0);
        runFrame("overrun", 4, 1, 10, 3, 0, 1'b0, 1'b1, 1'b0);
        runFrame("saturate", 2000, 1, 2, 1, 0, 1'b0, 1'b0, 1'b0);
        runFrame("stale_ready", 2, 4, 5, 4, 0, 1'b0, 1'b0, 1'b0);
        runFrame("done_collision", 1, 1, 2, 2, 0, 1'b0, 1'b0, 1'b1);
        runFrame("after_collision", 2, 1, 1, 1, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            n  = int'($urandom_range(0, 6));
            bp = int'($urandom_range(0, 4));
            runFrame($sformatf("random%0d", i), n, int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
                     int'($urandom_range(1, 8)), bp, (bp >= 2) && ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
        end

        // Abandon a frame with reset while the first object is in flight
        p_stale = 1; p_low = 3; p_fd = 20; p_bp = 0; p_spur = 1'b0;
        starts_seen = 0; clears_seen = 0; dones_seen = 0;
        req_start = 1'b1;
        req_n     = 3;
        cyc       = 0;
        while (starts_seen == 0 && cyc < 100) begin
            stepCycle();
            cyc++;
        end
        repeat (5) stepCycle();
        rst_cycles = 3;
        repeat (4) stepCycle();
        repeat (30) stepCycle();
        checkOutput("reset_abandon_done", dones_seen, 0);
        checkOutput("reset_abandon_starts", starts_seen, 1);
        checkOutput("reset_abandon_count", o_objects_rendered, 0);

        runFrame("post_reset", 2, 1, 2, 3, 1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
